pixel_word_bridge: RTL and testbench

Parametrised bridge between the micro's fixed-width GPIO command word and the pixel-wide frame buffer port. Unpacks incoming words into a pixel write stream and packs pixels read from the buffer into words for the micro. Generalises the fixed 4×8-bit read-side shift packer with configurable pixel and word widths, frame-length tracking, partial-last-word padding, read-latency compensation and a load path. Sits between file_register and bram_control.

---
 rtl/pixel_word_bridge.sv | 187 ++++++++++++++++++
 tb/tb_pixel_word_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_word_bridge.sv
// pixel_word_bridge
//   Bridges the micro's NB_WORD-wide command word and the NB_PIXEL-wide frame
//   buffer port.
//   Load side: each accepted word is unpacked MSB slice first into a pixel
//   write stream. Load side: the frame position is tracked so that the last
//   word of a frame may be cut short.
//   Read side: each accepted word request issues up to PPW pixel reads. The
//   returned pixels are packed MSB first. A short final word is zero padded in
//   its low slices.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   i_word_valid/i_word   load word offered by the micro
//   o_word_ready          load word accepted when high together with i_word_valid
//   o_pix_load_valid/o_pix_load  pixel write strobe and pixel to the buffer
//   o_load_done           one-cycle pulse after the last pixel of a frame
//   i_frame_ready         buffer holds a readable frame
//   i_word_req            micro requests the next packed word (pulse)
//   o_pix_read_req        pixel read strobe to the buffer
//   i_pix_rd_data         buffer read data, READ_LATENCY cycles after a strobe
//   o_rd_word_valid       one-cycle pulse when o_rd_word is complete
//   o_rd_word/o_rd_word_last  packed word and end-of-frame flag, held
//   o_busy                either side is working
module pixel_word_bridge #(
  parameter int NB_PIXEL     = 8,
  parameter int NB_WORD      = 32,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_word_valid,
  input  logic [NB_WORD-1:0]  i_word,
  output logic                o_word_ready,
  output logic                o_pix_load_valid,
  output logic [NB_PIXEL-1:0] o_pix_load,
  output logic                o_load_done,
  input  logic                i_frame_ready,
  input  logic                i_word_req,
  output logic                o_pix_read_req,
  input  logic [NB_PIXEL-1:0] i_pix_rd_data,
  output logic                o_rd_word_valid,
  output logic [NB_WORD-1:0]  o_rd_word,
  output logic                o_rd_word_last,
  output logic                o_busy
);

  localparam int PPW       = NB_WORD / NB_PIXEL;
  localparam int FRAME_PIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW        = $clog2(FRAME_PIX + 1);
  localparam int SW        = $clog2(PPW + 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIX - 1);

  typedef enum logic {L_IDLE, L_SHIFT} lstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DONE} rstate_t;

  lstate_t           lstate;
  rstate_t           rstate;
  logic [NB_WORD-1:0] load_sr;
  logic [SW-1:0]     lslot;
  logic [CW-1:0]     lcount;

  logic [SW-1:0]     issue_left;
  logic [SW-1:0]     cap_cnt;
  logic [SW-1:0]     n_word;
  logic [CW-1:0]     rcount;
  logic [NB_WORD-1:0] acc;
  logic [READ_LATENCY-1:0] rd_vld_p;

  logic              load_accept;
  logic              read_accept;
  logic              cap;
  logic [SW-1:0]     n_next;
  logic [NB_WORD-1:0] acc_next;
  int                remain;
  int                pad_bits;

  // Both sides share one handshake window: nothing is accepted while either works.
  assign o_word_ready     = (lstate == L_IDLE) && (rstate == R_IDLE);
  assign o_busy           = !o_word_ready;
  assign load_accept      = i_word_valid && o_word_ready;
  // A simultaneous load word takes priority; the read request is dropped.
  assign read_accept      = i_word_req && o_word_ready && i_frame_ready && !i_word_valid;
  assign o_pix_load_valid = (lstate == L_SHIFT);
  assign o_pix_load       = load_sr[NB_WORD-1 -: NB_PIXEL];
  assign o_pix_read_req   = (rstate == R_ISSUE);
  assign cap              = rd_vld_p[READ_LATENCY-1];

  always_comb begin
    remain   = FRAME_PIX - int'(rcount);
    n_next   = (remain >= PPW) ? SW'(PPW) : SW'(remain);
    acc_next = (acc << NB_PIXEL) | NB_WORD'(i_pix_rd_data);
    pad_bits = (PPW - int'(n_word)) * NB_PIXEL;
  end

  // Load side: unpack the latched word one slice per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lstate      <= L_IDLE;
      load_sr     <= '0;
      lslot       <= '0;
      lcount      <= '0;
      o_load_done <= 1'b0;
    end else begin
      o_load_done <= 1'b0;
      case (lstate)
        L_IDLE: begin
          if (load_accept) begin
            load_sr <= i_word;
            lslot   <= '0;
            lstate  <= L_SHIFT;
          end
        end
        L_SHIFT: begin
          load_sr <= load_sr << NB_PIXEL;
          lslot   <= lslot + SW'(1);
          if (lcount == FRAME_LAST) begin
            // Frame complete: any remaining slices of this word are dropped.
            lcount      <= '0;
            o_load_done <= 1'b1;
            lstate      <= L_IDLE;
          end else begin
            lcount <= lcount + CW'(1);
            if (lslot == SW'(PPW - 1)) lstate <= L_IDLE;
          end
        end
        default: lstate <= L_IDLE;
      endcase
    end
  end

  // Read side: issue strobes, align returns via the valid pipe, pack the word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rstate          <= R_IDLE;
      issue_left      <= '0;
      cap_cnt         <= '0;
      n_word          <= '0;
      rcount          <= '0;
      rd_vld_p        <= '0;
      o_rd_word       <= '0;
      o_rd_word_valid <= 1'b0;
      o_rd_word_last  <= 1'b0;
    end else begin
      o_rd_word_valid <= 1'b0;
      // Stage boundary: strobe -> data return, READ_LATENCY cycles deep.
      rd_vld_p <= (rd_vld_p << 1) | READ_LATENCY'(o_pix_read_req);
      if (cap) begin
        acc     <= acc_next;
        cap_cnt <= cap_cnt + SW'(1);
      end
      case (rstate)
        R_IDLE: begin
          if (read_accept) begin
            n_word     <= n_next;
            issue_left <= n_next;
            cap_cnt    <= '0;
            rstate     <= R_ISSUE;
          end
        end
        R_ISSUE: begin
          issue_left <= issue_left - SW'(1);
          if (issue_left == SW'(1)) rstate <= R_WAIT;
        end
        R_WAIT: begin
          if (cap && (cap_cnt == n_word - SW'(1))) begin
            // Left-justify a short word so its pixels sit in the MSB slices.
            o_rd_word       <= acc_next << pad_bits;
            o_rd_word_valid <= 1'b1;
            if (int'(rcount) + int'(n_word) == FRAME_PIX) begin
              o_rd_word_last <= 1'b1;
              rcount         <= '0;
            end else begin
              o_rd_word_last <= 1'b0;
              rcount         <= rcount + CW'(n_word);
            end
            rstate <= R_DONE;
          end
        end
        R_DONE:  rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_word_bridge.sv
// Bench for pixel_word_bridge: a default instance (10x10, latency 1) and a
// small-frame instance (3x3, latency 3) driven side by side. A transaction
// model schedules the expected per-cycle outputs from each accepted request.
// One compare process checks every cycle against that schedule.
module tb_pixel_word_bridge;
  localparam int MAXC = 4096;
  localparam int PPW  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        word_valid [2];
  logic [31:0] word [2];
  logic        word_ready [2];
  logic        pix_load_valid [2];
  logic [7:0]  pix_load [2];
  logic        load_done [2];
  logic        frame_ready [2];
  logic        word_req [2];
  logic        pix_read_req [2];
  logic [7:0]  pix_rd_data [2];
  logic        rd_word_valid [2];
  logic [31:0] rd_word [2];
  logic        rd_word_last [2];
  logic        busy [2];

  pixel_word_bridge #(.NB_PIXEL(8), .NB_WORD(32), .IMAGE_WIDTH(10), .IMAGE_HEIGHT(10),
                      .READ_LATENCY(1)) u_a (
    .clock(clock), .reset(reset),
    .i_word_valid(word_valid[0]), .i_word(word[0]), .o_word_ready(word_ready[0]),
    .o_pix_load_valid(pix_load_valid[0]), .o_pix_load(pix_load[0]), .o_load_done(load_done[0]),
    .i_frame_ready(frame_ready[0]), .i_word_req(word_req[0]), .o_pix_read_req(pix_read_req[0]),
    .i_pix_rd_data(pix_rd_data[0]), .o_rd_word_valid(rd_word_valid[0]), .o_rd_word(rd_word[0]),
    .o_rd_word_last(rd_word_last[0]), .o_busy(busy[0]));

  pixel_word_bridge #(.NB_PIXEL(8), .NB_WORD(32), .IMAGE_WIDTH(3), .IMAGE_HEIGHT(3),
                      .READ_LATENCY(3)) u_b (
    .clock(clock), .reset(reset),
    .i_word_valid(word_valid[1]), .i_word(word[1]), .o_word_ready(word_ready[1]),
    .o_pix_load_valid(pix_load_valid[1]), .o_pix_load(pix_load[1]), .o_load_done(load_done[1]),
    .i_frame_ready(frame_ready[1]), .i_word_req(word_req[1]), .o_pix_read_req(pix_read_req[1]),
    .i_pix_rd_data(pix_rd_data[1]), .o_rd_word_valid(rd_word_valid[1]), .o_rd_word(rd_word[1]),
    .o_rd_word_last(rd_word_last[1]), .o_busy(busy[1]));

  int frame_n [2] = '{100, 9};
  int lat_n [2]   = '{1, 3};

  // Expected outputs per instance per cycle, filled in when a request is accepted.
  bit          e_lv [2][MAXC];
  logic [7:0]  e_pix [2][MAXC];
  bit          e_done [2][MAXC];
  bit          e_rr [2][MAXC];
  bit          e_rv [2][MAXC];
  bit          e_busy [2][MAXC];
  bit          e_last [2][MAXC];
  logic [31:0] e_w [2][MAXC];

  logic [7:0]  mem [2][100];
  bit          rd_ok [2][MAXC];
  logic [7:0]  rd_val [2][MAXC];
  int          baddr [2];

  int          lidx [2];
  int          ridx [2];
  logic [31:0] held_w [2];
  bit          held_l [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", name, inst, cyc, act, exp);
    end
  endtask

  // Frame buffer stand-in: returns stored pixels READ_LATENCY cycles after each strobe.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) baddr[i] = 0;
      else if (pix_read_req[i] === 1'b1) begin
        if (cyc + lat_n[i] < MAXC) begin
          rd_ok[i][cyc + lat_n[i]]  = 1'b1;
          rd_val[i][cyc + lat_n[i]] = mem[i][baddr[i]];
        end
        baddr[i] = (baddr[i] + 1) % frame_n[i];
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        held_w[i] = 32'd0;
        held_l[i] = 1'b0;
        check("rst_word_ready", i, word_ready[i], 1);
        check("rst_busy", i, busy[i], 0);
        check("rst_load_valid", i, pix_load_valid[i], 0);
        check("rst_pix_load", i, pix_load[i], 0);
        check("rst_load_done", i, load_done[i], 0);
        check("rst_read_req", i, pix_read_req[i], 0);
        check("rst_rd_valid", i, rd_word_valid[i], 0);
        check("rst_rd_word", i, rd_word[i], 0);
        check("rst_rd_last", i, rd_word_last[i], 0);
      end else if (cyc < MAXC) begin
        check("load_valid", i, pix_load_valid[i], e_lv[i][cyc]);
        if (e_lv[i][cyc]) check("pix_load", i, pix_load[i], e_pix[i][cyc]);
        check("load_done", i, load_done[i], e_done[i][cyc]);
        check("read_req", i, pix_read_req[i], e_rr[i][cyc]);
        check("rd_valid", i, rd_word_valid[i], e_rv[i][cyc]);
        if (e_rv[i][cyc]) begin
          held_w[i] = e_w[i][cyc];
          held_l[i] = e_last[i][cyc];
        end
        check("rd_word", i, rd_word[i], held_w[i]);
        check("rd_last", i, rd_word_last[i], held_l[i]);
        check("word_ready", i, word_ready[i], !e_busy[i][cyc]);
        check("busy", i, busy[i], e_busy[i][cyc]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++)
      pix_rd_data[i] = (cyc < MAXC && rd_ok[i][cyc]) ? rd_val[i][cyc] : 8'($urandom);
  endtask

  // Drive one instance for the current cycle and record what an acceptance implies.
  task automatic apply(input int i, input bit v, input logic [31:0] w, input bit rq, input bit fr);
    int k;
    int n;
    logic [31:0] wd;
    word_valid[i]  = v;
    word[i]        = w;
    word_req[i]    = rq;
    frame_ready[i] = fr;
    if (reset && !e_busy[i][cyc]) begin
      if (v) begin
        k = (frame_n[i] - lidx[i] < PPW) ? frame_n[i] - lidx[i] : PPW;
        for (int j = 0; j < k; j++) begin
          e_lv[i][cyc + 1 + j]   = 1'b1;
          e_pix[i][cyc + 1 + j]  = w[31 - 8*j -: 8];
          e_busy[i][cyc + 1 + j] = 1'b1;
        end
        lidx[i] += k;
        if (lidx[i] == frame_n[i]) begin
          e_done[i][cyc + k + 1] = 1'b1;
          lidx[i] = 0;
        end
      end else if (rq && fr) begin
        n = (frame_n[i] - ridx[i] < PPW) ? frame_n[i] - ridx[i] : PPW;
        wd = 32'd0;
        for (int j = 0; j < PPW; j++)
          wd = (wd << 8) | ((j < n) ? 32'(mem[i][ridx[i] + j]) : 32'd0);
        for (int j = 1; j <= n; j++) e_rr[i][cyc + j] = 1'b1;
        for (int j = 1; j <= n + lat_n[i] + 1; j++) e_busy[i][cyc + j] = 1'b1;
        e_rv[i][cyc + n + lat_n[i] + 1]   = 1'b1;
        e_w[i][cyc + n + lat_n[i] + 1]    = wd;
        e_last[i][cyc + n + lat_n[i] + 1] = (ridx[i] + n == frame_n[i]);
        ridx[i] = (ridx[i] + n == frame_n[i]) ? 0 : ridx[i] + n;
      end
    end
  endtask

  task automatic idle_all();
    apply(0, 1'b0, 32'd0, 1'b0, 1'b0);
    apply(1, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic run_until(input int c);
    while (cyc < c) begin
      tick();
      idle_all();
    end
  endtask

  task automatic load_when_idle(input int i, input logic [31:0] w, output int t);
    bit sent = 1'b0;
    t = 0;
    while (!sent) begin
      tick();
      if (!e_busy[i][cyc]) begin
        apply(i, 1'b1, w, 1'b0, 1'b0);
        t = cyc;
        sent = 1'b1;
      end else apply(i, 1'b0, 32'd0, 1'b0, 1'b0);
      apply(1 - i, 1'b0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic req_when_idle(input int i, output int t);
    bit sent = 1'b0;
    t = 0;
    while (!sent) begin
      tick();
      if (!e_busy[i][cyc]) begin
        apply(i, 1'b0, 32'd0, 1'b1, 1'b1);
        t = cyc;
        sent = 1'b1;
      end else apply(i, 1'b0, 32'd0, 1'b0, 1'b1);
      apply(1 - i, 1'b0, 32'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      lidx[i] = 0;
      ridx[i] = 0;
      for (int c = cyc; c < MAXC; c++) begin
        e_lv[i][c]   = 1'b0;
        e_done[i][c] = 1'b0;
        e_rr[i][c]   = 1'b0;
        e_rv[i][c]   = 1'b0;
        e_busy[i][c] = 1'b0;
      end
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      word_valid[i] = 1'b0; word[i] = 32'd0; word_req[i] = 1'b0;
      frame_ready[i] = 1'b0; pix_rd_data[i] = 8'd0;
      lidx[i] = 0; ridx[i] = 0;
      for (int a = 0; a < 100; a++) mem[i][a] = 8'($urandom);
    end
    mem[0][0] = 8'h11; mem[0][1] = 8'h22; mem[0][2] = 8'h33; mem[0][3] = 8'h44;
    mem[1][8] = 8'h99;

    repeat (3) begin
      tick();
      idle_all();
    end
    check("lit_reset_ready", 0, word_ready[0], 1);
    check("lit_reset_busy", 1, busy[1], 0);
    tick();
    reset = 1'b1;
    idle_all();

    // Default frame load: pixels 1..100, four per word, MSB first.
    load_when_idle(0, 32'h01020304, t);
    for (int k = 1; k <= 4; k++) begin
      run_until(t + k);
      check("lit_first_pix", 0, pix_load[0], k);
      check("lit_first_vld", 0, pix_load_valid[0], 1);
    end
    for (int p = 1; p < 25; p++)
      load_when_idle(0, {8'(4*p+1), 8'(4*p+2), 8'(4*p+3), 8'(4*p+4)}, t);
    run_until(t + 4);
    check("lit_pix100", 0, pix_load[0], 8'h64);
    run_until(t + 5);
    check("lit_load_done", 0, load_done[0], 1);

    // Default frame read, with a request during busy that must be ignored.
    req_when_idle(0, t);
    tick();
    apply(0, 1'b0, 32'd0, 1'b1, 1'b1);
    apply(1, 1'b0, 32'd0, 1'b0, 1'b0);
    run_until(t + 5);
    check("lit_rd_early", 0, rd_word_valid[0], 0);
    run_until(t + 6);
    check("lit_rd_valid", 0, rd_word_valid[0], 1);
    check("lit_rd_word", 0, rd_word[0], 32'h11223344);
    run_until(t + 7);
    check("lit_rd_hold", 0, rd_word[0], 32'h11223344);
    for (int p = 1; p < 25; p++) req_when_idle(0, t);
    run_until(t + 6);
    check("lit_rd_last_vld", 0, rd_word_valid[0], 1);
    check("lit_rd_last", 0, rd_word_last[0], 1);

    // 3x3 frame load: third word contributes only its MSB pixel.
    for (int p = 0; p < 3; p++) load_when_idle(1, 32'hAABBCCDD, t);
    run_until(t + 1);
    check("lit_b_pix9", 1, pix_load[1], 8'hAA);
    run_until(t + 2);
    check("lit_b_vld_end", 1, pix_load_valid[1], 0);
    check("lit_b_done", 1, load_done[1], 1);

    // Request with frame not ready is ignored.
    tick();
    apply(1, 1'b0, 32'd0, 1'b1, 1'b0);
    apply(0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    idle_all();
    check("lit_b_nofr_req", 1, pix_read_req[1], 0);

    // 3x3 frame read: third word is one pixel, zero padded, latency 3.
    for (int p = 0; p < 3; p++) req_when_idle(1, t);
    run_until(t + 1);
    check("lit_b_strobe", 1, pix_read_req[1], 1);
    run_until(t + 2);
    check("lit_b_one_strobe", 1, pix_read_req[1], 0);
    run_until(t + 4);
    check("lit_b_rd_early", 1, rd_word_valid[1], 0);
    run_until(t + 5);
    check("lit_b_rd_valid", 1, rd_word_valid[1], 1);
    check("lit_b_rd_word", 1, rd_word[1], 32'h99000000);
    check("lit_b_rd_last", 1, rd_word_last[1], 1);

    // Load and read request together: load wins.
    run_until(cyc + 8);
    tick();
    apply(0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    apply(1, 1'b0, 32'd0, 1'b0, 1'b0);
    t = cyc;
    run_until(t + 1);
    check("lit_both_noread", 0, pix_read_req[0], 0);
    check("lit_both_load", 0, pix_load[0], 8'hDE);

    // Reset in the middle of the frame's final word: no done pulse afterwards.
    while (lidx[0] < 96) load_when_idle(0, $urandom, t);
    load_when_idle(0, 32'h0A0B0C0D, t);
    run_until(t + 2);
    check("lit_mid_pix", 0, pix_load[0], 8'h0B);
    #2 reset = 1'b0;
    #1;
    check("lit_async_vld", 0, pix_load_valid[0], 0);
    check("lit_async_ready", 0, word_ready[0], 1);
    check("lit_async_busy", 0, busy[0], 0);
    clear_model();
    tick();
    reset = 1'b1;
    idle_all();
    for (int k = 0; k < 6; k++) begin
      tick();
      idle_all();
      check("lit_no_done", 0, load_done[0], 0);
    end

    // Random traffic on both instances.
    for (int n = 0; n < 2500 && cyc + 20 < MAXC; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        int r;
        r = $urandom_range(0, 9);
        apply(i, (r <= 2) || (r == 6), $urandom, (r >= 3 && r <= 7),
              (r == 7) ? 1'b0 : ((r >= 3) ? 1'b1 : 1'($urandom)));
      end
    end
    run_until(cyc + 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
